// File: rtl/bs_pkg.sv
// bs_pkg: types and sizing helpers shared by the bit-serial SHA-256 stages.
package bs_pkg;

    localparam int BS_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH
    } bs_ser_state_t;

    // Width of a counter that holds 0..n-1; never narrower than one bit.
    function automatic int bs_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bs_bclk_div.sv
// bs_bclk_div: counts DIV clk cycles per bclk half-period and flags the last one.
module bs_bclk_div
    import bs_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic phase_end
);

    localparam int DCW = bs_cnt_w(DIV);
    localparam logic [DCW-1:0] DLAST = DCW'(DIV - 1);

    logic [DCW-1:0] dcnt_q, dcnt_d;

    assign phase_end = enable && (dcnt_q == DLAST);

    always_comb begin
        dcnt_d = dcnt_q;
        if (clear) begin
            dcnt_d = '0;
        end else if (enable) begin
            dcnt_d = phase_end ? '0 : dcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt_q <= '0;
        end else begin
            dcnt_q <= dcnt_d;
        end
    end

endmodule

// File: rtl/bs_word_serializer.sv
// bs_word_serializer: accepts a word over valid/ready and emits bclk, counter and the serial bit stream.
// Define BS_SER_LSB_FIRST_EN to send bits LSB first; the default build sends MSB first.
module bs_word_serializer
    import bs_pkg::*;
#(
    parameter int W   = BS_W,
    parameter int DIV = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   word_valid,
    input  logic [W-1:0]           word_in,
    output logic                   word_ready,
    output logic                   bclk,
    output logic [bs_cnt_w(W)-1:0] counter,
    output logic                   out,
    output logic                   busy,
    output logic                   done
);

    localparam int CW = bs_cnt_w(W);
    localparam logic [CW-1:0] CLAST = CW'(W - 1);

    bs_ser_state_t state_q, state_d;
    logic [W-1:0]  shiftReg_q, shiftReg_d;
    logic [CW-1:0] bitCnt_q, bitCnt_d;
    logic          bclk_q, bclk_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          idle;
    logic          phaseEnd;

    assign idle = (state_q == IDLE);

    bs_bclk_div #(
        .DIV(DIV)
    ) uDiv (
        .clk      (clk),
        .rst      (rst),
        .clear    (idle),
        .enable   (!idle),
        .phase_end(phaseEnd)
    );

    // The bit on the wire is always the end of the shift register nearest the output.
`ifdef BS_SER_LSB_FIRST_EN
    assign out = shiftReg_q[0];
`else
    assign out = shiftReg_q[W-1];
`endif

    assign word_ready = idle;
    assign bclk       = bclk_q;
    assign counter    = bitCnt_q;
    assign busy       = busy_q;
    assign done       = done_q;

    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        bitCnt_d   = bitCnt_q;
        bclk_d     = bclk_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (word_valid) begin
                    state_d    = LOW;
                    shiftReg_d = word_in;
                    bitCnt_d   = '0;
                    bclk_d     = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            LOW: begin
                if (phaseEnd) begin
                    state_d = HIGH;
                    bclk_d  = 1'b1;
                end
            end
            HIGH: begin
                if (phaseEnd) begin
                    bclk_d = 1'b0;
                    if (bitCnt_q == CLAST) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Falling edge: advance to the next bit together with the counter.
                        state_d  = LOW;
                        bitCnt_d = bitCnt_q + 1'b1;
`ifdef BS_SER_LSB_FIRST_EN
                        shiftReg_d = {1'b0, shiftReg_q[W-1:1]};
`else
                        shiftReg_d = {shiftReg_q[W-2:0], 1'b0};
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            bitCnt_q   <= '0;
            bclk_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            bitCnt_q   <= bitCnt_d;
            bclk_q     <= bclk_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

endmodule
